// File: rtl/lfsr_rand_pkg.sv
// Shared types, default constants and the Galois step helper for lfsr_rand_arbiter.
package lfsr_rand_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_STEP    = 2'd1,
    ST_DELIVER = 2'd2
  } arb_state_e;

  localparam int          LFSR_MAX_W = 64;
  localparam logic [31:0] DEF_TAPS   = 32'h80200003;
  localparam logic [31:0] DEF_SEED   = 32'h00000001;

  // One right-shifting Galois step; narrower LFSRs are zero-extended by the caller.
  function automatic logic [LFSR_MAX_W-1:0] lfsr_next(
    input logic [LFSR_MAX_W-1:0] state,
    input logic [LFSR_MAX_W-1:0] taps
  );
    logic [LFSR_MAX_W-1:0] shifted;
    shifted   = state >> 1;
    lfsr_next = state[0] ? (shifted ^ taps) : shifted;
  endfunction

endpackage

// File: rtl/lfsr_rand_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set req bit at or above ptr, wrapping.
module rr_arbiter
  import lfsr_rand_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   winner,
  output logic               any_req
);

  int idx_s;

  // Scan from the farthest slot down so the nearest set bit after ptr is assigned last.
  always_comb begin
    winner  = {IDX_W{1'b0}};
    any_req = |req;
    idx_s   = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx_s = (int'(ptr) + k) % NUM_REQ;
      if (req[idx_s]) begin
        winner = IDX_W'(idx_s);
      end else begin
        winner = winner;
      end
    end
  end

endmodule

// File: rtl/lfsr_rand_arbiter.sv
// Round-robin random-number server around a single Galois LFSR.
// Optional build macro LFSR_ARB_FREE_RUN_EN: LFSR also advances in idle cycles.
module lfsr_rand_arbiter
  import lfsr_rand_pkg::*;
#(
  parameter int               NUM_REQ = 4,
  parameter int               WIDTH   = 32,
  parameter logic [WIDTH-1:0] TAPS    = WIDTH'(DEF_TAPS),
  parameter logic [WIDTH-1:0] SEED    = WIDTH'(DEF_SEED),
  parameter int               STEPS   = 8
) (
  input  logic               ACLK,
  input  logic               ARESETN,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic               rnd_valid,
  output logic [WIDTH-1:0]   rnd_data,
  input  logic               seed_load,
  input  logic [WIDTH-1:0]   seed_val,
  output logic               busy
);

  localparam int                 IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [7:0]         STEPS_M1 = 8'(STEPS - 1);
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] GNT_LSB  = {{(NUM_REQ-1){1'b0}}, 1'b1};

  arb_state_e          state_r, state_nxt_s;
  logic [WIDTH-1:0]    lfsr_r, lfsr_nxt_s, lfsr_step_s;
  logic [7:0]          cnt_r, cnt_nxt_s;
  logic [IDX_W-1:0]    winner_r, winner_nxt_s, ptr_r, ptr_nxt_s, win_s;
  logic                any_req_s;
  logic                pend_r, pend_nxt_s;
  logic [WIDTH-1:0]    pend_val_r, pend_val_nxt_s;
  logic [WIDTH-1:0]    rnd_data_r, rnd_data_nxt_s;
  logic [NUM_REQ-1:0]  gnt_r, gnt_nxt_s;
  logic                rnd_valid_r, busy_r;

  // An all-zero seed would lock the LFSR, so it is replaced by SEED.
  function automatic logic [WIDTH-1:0] seed_fix(input logic [WIDTH-1:0] v);
    seed_fix = (v == {WIDTH{1'b0}}) ? SEED : v;
  endfunction

  assign lfsr_step_s = WIDTH'(lfsr_next(64'(lfsr_r), 64'(TAPS)));

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .req     (req),
    .ptr     (ptr_r),
    .winner  (win_s),
    .any_req (any_req_s)
  );

  // Next-state, LFSR, counter, pointer and pending-seed computation.
  always_comb begin
    state_nxt_s    = state_r;
    lfsr_nxt_s     = lfsr_r;
    cnt_nxt_s      = cnt_r;
    winner_nxt_s   = winner_r;
    ptr_nxt_s      = ptr_r;
    pend_nxt_s     = pend_r;
    pend_val_nxt_s = pend_val_r;
    rnd_data_nxt_s = rnd_data_r;
    case (state_r)
      ST_IDLE: begin
        if (seed_load || pend_r) begin
          // A fresh strobe is newer than anything latched while busy.
          lfsr_nxt_s = seed_fix(seed_load ? seed_val : pend_val_r);
          pend_nxt_s = 1'b0;
        end else begin
`ifdef LFSR_ARB_FREE_RUN_EN
          lfsr_nxt_s = lfsr_step_s;
`else
          lfsr_nxt_s = lfsr_r;
`endif
          if (any_req_s) begin
            winner_nxt_s = win_s;
            cnt_nxt_s    = STEPS_M1;
            state_nxt_s  = ST_STEP;
          end else begin
            state_nxt_s  = ST_IDLE;
          end
        end
      end
      ST_STEP: begin
        lfsr_nxt_s = lfsr_step_s;
        if (cnt_r == 8'd0) begin
          state_nxt_s    = ST_DELIVER;
          rnd_data_nxt_s = lfsr_step_s;
        end else begin
          cnt_nxt_s      = cnt_r - 8'd1;
        end
        if (seed_load) begin
          pend_nxt_s     = 1'b1;
          pend_val_nxt_s = seed_val;
        end else begin
          pend_nxt_s     = pend_r;
        end
      end
      ST_DELIVER: begin
        state_nxt_s = ST_IDLE;
        ptr_nxt_s   = (winner_r == LAST_IDX) ? {IDX_W{1'b0}} : winner_r + IDX_W'(1);
        if (seed_load) begin
          pend_nxt_s     = 1'b1;
          pend_val_nxt_s = seed_val;
        end else begin
          pend_nxt_s     = pend_r;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Outputs are precomputed from the next state so they leave the block registered.
  always_comb begin
    gnt_nxt_s = {NUM_REQ{1'b0}};
    if (state_nxt_s == ST_DELIVER) begin
      gnt_nxt_s = GNT_LSB << winner_nxt_s;
    end else begin
      gnt_nxt_s = {NUM_REQ{1'b0}};
    end
  end

  // State and output registers.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_r     <= ST_IDLE;
      lfsr_r      <= SEED;
      cnt_r       <= 8'd0;
      winner_r    <= {IDX_W{1'b0}};
      ptr_r       <= {IDX_W{1'b0}};
      pend_r      <= 1'b0;
      pend_val_r  <= {WIDTH{1'b0}};
      rnd_data_r  <= {WIDTH{1'b0}};
      gnt_r       <= {NUM_REQ{1'b0}};
      rnd_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      lfsr_r      <= lfsr_nxt_s;
      cnt_r       <= cnt_nxt_s;
      winner_r    <= winner_nxt_s;
      ptr_r       <= ptr_nxt_s;
      pend_r      <= pend_nxt_s;
      pend_val_r  <= pend_val_nxt_s;
      rnd_data_r  <= rnd_data_nxt_s;
      gnt_r       <= gnt_nxt_s;
      rnd_valid_r <= (state_nxt_s == ST_DELIVER);
      busy_r      <= (state_nxt_s != ST_IDLE);
    end
  end

  assign gnt       = gnt_r;
  assign rnd_valid = rnd_valid_r;
  assign rnd_data  = rnd_data_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_lfsr_rand_arbiter.sv
// Self-checking bench: directed scenarios on a STEPS=1 instance, randomized
// transactions on a STEPS=5 / NUM_REQ=5 instance, both against a reference model.
module tb_lfsr_rand_arbiter;

  localparam logic [31:0] TAPS = 32'h80200003;
  localparam logic [31:0] SEED = 32'h00000001;
  localparam int NA = 4;
  localparam int SA = 1;
  localparam int NB = 5;
  localparam int SB = 5;

  logic          aclk    = 1'b0;
  logic          aresetn = 1'b0;
  logic [NA-1:0] req_a   = '0;
  logic [NA-1:0] gnt_a;
  logic          rnd_valid_a, busy_a;
  logic [31:0]   rnd_data_a;
  logic          seed_load_a = 1'b0;
  logic [31:0]   seed_val_a  = 32'h0;
  logic [NB-1:0] req_b   = '0;
  logic [NB-1:0] gnt_b;
  logic          rnd_valid_b, busy_b;
  logic [31:0]   rnd_data_b;
  logic          seed_load_b = 1'b0;
  logic [31:0]   seed_val_b  = 32'h0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 aclk = ~aclk;

  lfsr_rand_arbiter #(.NUM_REQ(NA), .WIDTH(32), .TAPS(TAPS), .SEED(SEED), .STEPS(SA)) u_dut_a (
    .ACLK(aclk), .ARESETN(aresetn), .req(req_a), .gnt(gnt_a), .rnd_valid(rnd_valid_a),
    .rnd_data(rnd_data_a), .seed_load(seed_load_a), .seed_val(seed_val_a), .busy(busy_a)
  );

  lfsr_rand_arbiter #(.NUM_REQ(NB), .WIDTH(32), .TAPS(TAPS), .SEED(SEED), .STEPS(SB)) u_dut_b (
    .ACLK(aclk), .ARESETN(aresetn), .req(req_b), .gnt(gnt_b), .rnd_valid(rnd_valid_b),
    .rnd_data(rnd_data_b), .seed_load(seed_load_b), .seed_val(seed_val_b), .busy(busy_b)
  );

  task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // Reference model: plain Galois rule and round-robin search.
  function automatic logic [31:0] ref_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ TAPS) : (s >> 1);
  endfunction

  function automatic logic [31:0] ref_advance(input logic [31:0] s, input int n);
    logic [31:0] t = s;
    for (int i = 0; i < n; i++) t = ref_step(t);
    return t;
  endfunction

  function automatic int ref_pick(input logic [7:0] r, input int ptr, input int n);
    for (int k = 0; k < n; k++) begin
      if (r[(ptr + k) % n]) return (ptr + k) % n;
    end
    return -1;
  endfunction

  task automatic peek(input int which, output logic [7:0] g, output logic [31:0] d,
                      output logic v, output logic b);
    if (which == 0) begin
      g = 8'(gnt_a); d = rnd_data_a; v = rnd_valid_a; b = busy_a;
    end else begin
      g = 8'(gnt_b); d = rnd_data_b; v = rnd_valid_b; b = busy_b;
    end
  endtask

  task automatic wait_grant(input int which, input int budget, output int lat,
                            output logic [7:0] g, output logic [31:0] d,
                            output logic v, output logic b);
    lat = 0; g = 8'd0; d = 32'd0; v = 1'b0; b = 1'b0;
    while (lat < budget) begin
      @(negedge aclk);
      lat++;
      peek(which, g, d, v, b);
      if (g != 8'd0 || v) break;
    end
  endtask

  task automatic expect_grant(input int which, input string tag, input int exp_idx,
                              input logic [31:0] exp_data, input int exp_lat);
    int          lat;
    logic [7:0]  g, eg;
    logic [31:0] d;
    logic        v, b;
    eg = 8'd1 << exp_idx;
    wait_grant(which, exp_lat + 4, lat, g, d, v, b);
    check_value({tag, "_gnt"},     64'(g),   64'(eg));
    check_value({tag, "_data"},    64'(d),   64'(exp_data));
    check_value({tag, "_valid"},   64'(v),   64'(1'b1));
    check_value({tag, "_busy"},    64'(b),   64'(1'b1));
    check_value({tag, "_latency"}, 64'(lat), 64'(exp_lat));
  endtask

  task automatic expect_idle(input int which, input string tag, input logic [31:0] held);
    logic [7:0]  g;
    logic [31:0] d;
    logic        v, b;
    @(negedge aclk);
    peek(which, g, d, v, b);
    check_value({tag, "_idle_gnt"},  64'(g), 64'd0);
    check_value({tag, "_idle_valid"},64'(v), 64'd0);
    check_value({tag, "_idle_busy"}, 64'(b), 64'd0);
    check_value({tag, "_idle_hold"}, 64'(d), 64'(held));
  endtask

  task automatic do_reset();
    req_a = '0; req_b = '0; seed_load_a = 1'b0; seed_load_b = 1'b0;
    aresetn = 1'b0;
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
  endtask

  logic [31:0] ma_lfsr, mb_lfsr, sv, exp_fr;
  logic [31:0] t1_exp [3];
  int          ma_ptr, mb_ptr, w, seen;
  logic [7:0]  r8;

  initial begin
    t1_exp[0] = 32'h80200003;
    t1_exp[1] = 32'hC0300002;
    t1_exp[2] = 32'h60180001;

    // Reset values
    do_reset();
    check_value("rst_gnt",   64'(gnt_a),       64'd0);
    check_value("rst_valid", 64'(rnd_valid_a), 64'd0);
    check_value("rst_data",  64'(rnd_data_a),  64'd0);
    check_value("rst_busy",  64'(busy_a),      64'd0);
    check_value("rst_b_data",64'(rnd_data_b),  64'd0);

    // Single requester, known sequence
    ma_lfsr = SEED; ma_ptr = 0;
    for (int i = 0; i < 3; i++) begin
      req_a = 4'b0001;
      expect_grant(0, "seq", 0, t1_exp[i], SA + 1);
      check_value("seq_model", 64'(ref_advance(ma_lfsr, SA)), 64'(t1_exp[i]));
      ma_lfsr = t1_exp[i];
      req_a = 4'b0000;
      expect_idle(0, "seq", ma_lfsr);
    end

    // All four held, each drops after its own grant
    do_reset();
    ma_lfsr = SEED; ma_ptr = 0;
    req_a = 4'b1111;
    for (int i = 0; i < NA; i++) begin
      w = ref_pick(8'(req_a), ma_ptr, NA);
      check_value("rr_model_order", 64'(w), 64'(i));
      ma_lfsr = ref_advance(ma_lfsr, SA);
      expect_grant(0, "rr", i, ma_lfsr, (i == 0) ? SA + 1 : SA + 2);
      req_a[i] = 1'b0;
      ma_ptr = (w + 1) % NA;
    end
    expect_idle(0, "rr", ma_lfsr);

    // Zero seed in idle is replaced by SEED
    seed_load_a = 1'b1; seed_val_a = 32'h0;
    @(negedge aclk);
    seed_load_a = 1'b0;
    req_a = 4'b0100;
    expect_grant(0, "zseed", 2, 32'h80200003, SA + 1);
    ma_lfsr = 32'h80200003;
    ma_ptr = 3;
    req_a = 4'b0000;
    expect_idle(0, "zseed", ma_lfsr);

    // Seed while busy: old sequence now, new seed next idle, request delayed one cycle
    req_a = 4'b0010;
    @(negedge aclk);
    seed_load_a = 1'b1; seed_val_a = 32'h00000002;
    ma_lfsr = ref_step(ma_lfsr);
    expect_grant(0, "bseed_old", 1, ma_lfsr, SA);
    seed_load_a = 1'b0;
    req_a = 4'b1000;
    expect_grant(0, "bseed_new", 3, 32'h00000001, SA + 3);
    ma_lfsr = 32'h00000001;
    req_a = 4'b0000;
    expect_idle(0, "bseed", ma_lfsr);

    // Reset in the middle of a STEP phase
    req_a = 4'b0001;
    @(negedge aclk);
    aresetn = 1'b0;
    #1;
    check_value("mid_rst_gnt",   64'(gnt_a),       64'd0);
    check_value("mid_rst_valid", 64'(rnd_valid_a), 64'd0);
    check_value("mid_rst_data",  64'(rnd_data_a),  64'd0);
    check_value("mid_rst_busy",  64'(busy_a),      64'd0);
    req_a = 4'b0000;
    @(negedge aclk);
    aresetn = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge aclk);
      if (gnt_a != 4'b0000 || rnd_valid_a) seen++;
    end
    check_value("mid_rst_no_stale", 64'(seen), 64'd0);
    req_a = 4'b0001;
    expect_grant(0, "mid_rst_rereq", 0, 32'h80200003, SA + 1);
    req_a = 4'b0000;
    expect_idle(0, "mid_rst", 32'h80200003);

    // Idle cycles before a request
    do_reset();
    repeat (3) @(negedge aclk);
`ifdef LFSR_ARB_FREE_RUN_EN
    exp_fr = ref_advance(SEED, 4 + 1 + SA);
`else
    exp_fr = ref_advance(SEED, SA);
`endif
    req_a = 4'b0001;
    expect_grant(0, "freerun", 0, exp_fr, SA + 1);
    req_a = 4'b0000;
    expect_idle(0, "freerun", exp_fr);

    // Randomized transactions on the STEPS=5, NUM_REQ=5 instance
    do_reset();
    mb_lfsr = SEED; mb_ptr = 0;
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 3) == 0) begin
        sv = ($urandom_range(0, 3) == 0) ? 32'h0 : 32'($urandom);
        seed_load_b = 1'b1; seed_val_b = sv;
        @(negedge aclk);
        seed_load_b = 1'b0;
        mb_lfsr = (sv == 32'h0) ? SEED : sv;
      end
      r8 = 8'($urandom_range(1, 31));
      req_b = NB'(r8);
      w = ref_pick(r8, mb_ptr, NB);
      mb_lfsr = ref_advance(mb_lfsr, SB);
      expect_grant(1, "rand", w, mb_lfsr, SB + 1);
      mb_ptr = (w + 1) % NB;
      req_b = '0;
      expect_idle(1, "rand", mb_lfsr);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
